draw_scheduler: RTL

- Time-shares the oscilloscope XY DAC between up to N_REQ point generators: ball, left paddle, right paddle and score.
- Each frame starts on a single-cycle refresh tick. Requesters are served round-robin, one point per grant.
- Each granted point is held on the DAC for DWELL_CYCLES sysclk cycles.
- Sits between the tick source (5 kHz refresh enable) and the DAC output register stage.

---
 rtl/draw_pkg.sv | 19 +
 rtl/draw_scheduler_rr_arbiter.sv | 35 +++
 rtl/draw_scheduler.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/draw_pkg.sv
// Shared types and constants for the XY-DAC draw scheduler.
// The BLANK state is only entered when DRAW_SCHED_BLANK_EN is defined.
package draw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        DWELL = 2'd2,
        BLANK = 2'd3
    } draw_state_t;

    localparam int COORD_W_DEF = 8;

    localparam int REQ_BALL  = 0;
    localparam int REQ_PAD_L = 1;
    localparam int REQ_PAD_R = 2;
    localparam int REQ_SCORE = 3;

endpackage

// File: rtl/draw_scheduler_rr_arbiter.sv
// Combinational round-robin pick: the first set req bit at or after ptr wins,
// with the search wrapping modulo N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx,
    output logic             any
);

    logic [IW:0]   cand;
    logic [IW-1:0] c_idx;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        c_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr} + (IW+1)'(i);
            if (cand >= (IW+1)'(N_REQ)) cand = cand - (IW+1)'(N_REQ);
            c_idx = cand[IW-1:0];
            if (!any && req[c_idx]) begin
                any          = 1'b1;
                idx          = c_idx;
                grant[c_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// Time-shares the XY DAC between point generators, one point per grant, each held
// DWELL_CYCLES cycles. Define DRAW_SCHED_BLANK_EN to blank the beam on requester change.
module draw_scheduler
    import draw_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int COORD_W      = COORD_W_DEF,
    parameter int DWELL_CYCLES = 100,
    parameter int FRAME_POINTS = 400,
    parameter int BLANK_CYCLES = 20
) (
    input  logic                       sysclk,
    input  logic                       rst_n,
    input  logic                       tick_refresh,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*COORD_W-1:0]   x_in,
    input  logic [N_REQ*COORD_W-1:0]   y_in,
    output logic [N_REQ-1:0]           ack,
    output logic [COORD_W-1:0]         dac_x,
    output logic [COORD_W-1:0]         dac_y,
    output logic                       dac_valid,
    output logic                       blank,
    output logic                       frame_busy,
    output logic [7:0]                 overrun_cnt,
    output draw_state_t                state_dbg
);

    localparam int IW   = $clog2(N_REQ);
    localparam int PW   = $clog2(FRAME_POINTS + 1);
    localparam int TMAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
    localparam logic [PW-1:0] PTS_LAST   = PW'(FRAME_POINTS - 1);
    localparam logic [IW-1:0] PTR_LAST   = IW'(N_REQ - 1);

    draw_state_t      state;
    logic [IW-1:0]    ptr, win_idx, arb_idx, ptr_next;
    logic [N_REQ-1:0] win_oh, arb_grant;
    logic             arb_any;
    logic [TW-1:0]    timer;
    logic [PW-1:0]    pts;

`ifdef DRAW_SCHED_BLANK_EN
    localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
    logic          first_pt;
    logic [IW-1:0] prev_idx;
`else
    assign blank = 1'b0;
`endif

    assign state_dbg = state;
    assign ptr_next  = (win_idx == PTR_LAST) ? '0 : win_idx + 1'b1;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // ack is the only handshake: it is a one-cycle, one-hot pulse on the final dwell
    // cycle, registered one cycle ahead so it lines up with that cycle exactly.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            win_idx     <= '0;
            win_oh      <= '0;
            timer       <= '0;
            pts         <= '0;
            ack         <= '0;
            dac_x       <= '0;
            dac_y       <= '0;
            dac_valid   <= 1'b0;
            frame_busy  <= 1'b0;
            overrun_cnt <= '0;
`ifdef DRAW_SCHED_BLANK_EN
            blank       <= 1'b0;
            first_pt    <= 1'b0;
            prev_idx    <= '0;
`endif
        end else begin
            ack <= '0;
            if (tick_refresh && state != IDLE && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;
            case (state)
                IDLE: begin
                    if (tick_refresh) begin
                        state      <= ARB;
                        frame_busy <= 1'b1;
                        pts        <= '0;
`ifdef DRAW_SCHED_BLANK_EN
                        first_pt   <= 1'b1;
`endif
                    end
                end
                ARB: begin
                    if (arb_any) begin
                        dac_x   <= x_in[arb_idx*COORD_W +: COORD_W];
                        dac_y   <= y_in[arb_idx*COORD_W +: COORD_W];
                        win_idx <= arb_idx;
                        win_oh  <= arb_grant;
`ifdef DRAW_SCHED_BLANK_EN
                        if (first_pt || arb_idx != prev_idx) begin
                            state <= BLANK;
                            blank <= 1'b1;
                            timer <= BLANK_LAST;
                        end else begin
                            state     <= DWELL;
                            dac_valid <= 1'b1;
                            timer     <= DWELL_LAST;
                            if (DWELL_CYCLES == 1) ack <= arb_grant;
                        end
`else
                        state     <= DWELL;
                        dac_valid <= 1'b1;
                        timer     <= DWELL_LAST;
                        if (DWELL_CYCLES == 1) ack <= arb_grant;
`endif
                    end else begin
                        state      <= IDLE;
                        frame_busy <= 1'b0;
`ifdef DRAW_SCHED_BLANK_EN
                        blank      <= 1'b1;
`endif
                    end
                end
                DWELL: begin
                    if (timer == '0) begin
                        dac_valid <= 1'b0;
                        ptr       <= ptr_next;
                        pts       <= pts + 1'b1;
`ifdef DRAW_SCHED_BLANK_EN
                        prev_idx  <= win_idx;
                        first_pt  <= 1'b0;
`endif
                        if (pts == PTS_LAST) begin
                            state      <= IDLE;
                            frame_busy <= 1'b0;
`ifdef DRAW_SCHED_BLANK_EN
                            blank      <= 1'b1;
`endif
                        end else begin
                            state <= ARB;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                        if (timer == TW'(1)) ack <= win_oh;
                    end
                end
`ifdef DRAW_SCHED_BLANK_EN
                BLANK: begin
                    if (timer == '0) begin
                        state     <= DWELL;
                        blank     <= 1'b0;
                        dac_valid <= 1'b1;
                        timer     <= DWELL_LAST;
                        if (DWELL_CYCLES == 1) ack <= win_oh;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule
